// File: rtl/aes_pkg.sv
// Shared AES scheduler types and constants.
package aes_pkg;

  localparam int AES_NUM_ROUNDS = 10;
  localparam int AES_BLOCK_W    = 128;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ISSUE  = 2'd1,
    WAIT   = 2'd2,
    RESULT = 2'd3
  } sched_state_t;

  typedef enum logic {
    MODE_ENC = 1'b0,
    MODE_DEC = 1'b1
  } aes_mode_t;

endpackage

// File: rtl/rr_arbiter2.sv
// Two-way round-robin arbiter. req[0]/gnt[0] = encrypt, req[1]/gnt[1] = decrypt.
// On a tie the side opposite the last winner is granted; the winner register
// only moves when the caller strobes advance.
module rr_arbiter2
  import aes_pkg::*;
(
  input  logic       clk,
  input  logic       rst,
  input  logic [1:0] req,
  input  logic       advance,
  output logic [1:0] gnt
);

  aes_mode_t last_winner;

  // One-hot grant from the request pair and the last winner
  always_comb begin
    gnt = 2'b00;
    case (req)
      2'b01:   gnt = 2'b01;
      2'b10:   gnt = 2'b10;
      2'b11:   gnt = (last_winner == MODE_DEC) ? 2'b01 : 2'b10;
      default: gnt = 2'b00;
    endcase
  end

  // Remember who won the last accepted grant; dec after reset so enc wins first tie
  always_ff @(posedge clk or posedge rst) begin
    if (rst)
      last_winner <= MODE_DEC;
    else if (advance && (gnt != 2'b00))
      last_winner <= gnt[1] ? MODE_DEC : MODE_ENC;
  end

endmodule

// File: rtl/aes_core_scheduler.sv
// Shares one AES-128 round datapath between an encrypt and a decrypt requester.
// One block is in flight at a time: accept, run rounds 0..NUM_ROUNDS through the
// core (ISSUE pulses round_start, WAIT holds until round_done), then present the
// result until the consumer takes it.
module aes_core_scheduler
  import aes_pkg::*;
#(
  parameter int NUM_ROUNDS = AES_NUM_ROUNDS
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         enc_valid,
  output logic         enc_ready,
  input  logic [127:0] enc_data,
  input  logic         dec_valid,
  output logic         dec_ready,
  input  logic [127:0] dec_data,
  output logic         round_start,
  output logic [3:0]   round_num,
  output logic [3:0]   round_key_idx,
  output logic         round_mode,
  output logic         round_last,
  output logic [127:0] round_state_in,
  input  logic         round_done,
  input  logic [127:0] round_state_out,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [127:0] out_data,
  output logic         out_is_dec,
  output logic         busy
);

  localparam logic [3:0] LAST_RND = 4'(NUM_ROUNDS);

  sched_state_t             state;
  aes_mode_t                mode;
  logic [3:0]               rnd_q;
  logic [AES_BLOCK_W-1:0]   state_reg;
  logic [1:0]               req;
  logic [1:0]               gnt;
  logic                     accept;

  // Requests only compete while idle, so ready can never rise mid-block
  assign req    = {dec_valid, enc_valid} & {2{state == IDLE}};
  assign accept = |gnt;

  rr_arbiter2 u_arb (
    .clk     (clk),
    .rst     (rst),
    .req     (req),
    .advance (accept),
    .gnt     (gnt)
  );

  assign enc_ready = gnt[0];
  assign dec_ready = gnt[1];

  // Sequencer: accept a block, walk it through every round, hold the result
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= IDLE;
      mode      <= MODE_ENC;
      rnd_q     <= 4'd0;
      state_reg <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (accept) begin
            state_reg <= gnt[1] ? dec_data : enc_data;
            mode      <= gnt[1] ? MODE_DEC : MODE_ENC;
            rnd_q     <= 4'd0;
            state     <= ISSUE;
          end
        end
        ISSUE: begin
          // An out-of-range round index can only come from an upset; abandon the block
          state <= (rnd_q > LAST_RND) ? IDLE : WAIT;
        end
        WAIT: begin
          if (rnd_q > LAST_RND) begin
            state <= IDLE;
          end else if (round_done) begin
            state_reg <= round_state_out;
            if (rnd_q == LAST_RND) begin
              state <= RESULT;
            end else begin
              if (rnd_q != 4'hF)
                rnd_q <= rnd_q + 4'd1;
              state <= ISSUE;
            end
          end
        end
        RESULT: begin
          if (out_ready)
            state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  // All core/consumer-facing outputs decode registered state only
  assign busy           = (state != IDLE);
  assign round_start    = (state == ISSUE);
  assign round_num      = rnd_q;
  assign round_mode     = (mode == MODE_DEC);
  assign round_key_idx  = (mode == MODE_DEC) ? (LAST_RND - rnd_q) : rnd_q;
  assign round_last     = (rnd_q == LAST_RND);
  assign round_state_in = state_reg;
  assign out_valid      = (state == RESULT);
  assign out_data       = out_valid ? state_reg : '0;
  assign out_is_dec     = out_valid && (mode == MODE_DEC);

endmodule

// File: tb/tb_aes_core_scheduler.sv
// Scoreboard bench for aes_core_scheduler with a behavioural AES-128 round core
// keyed with the FIPS-197 C.1 key.
module tb_aes_core_scheduler;

  localparam logic [127:0] PT  = 128'h00112233445566778899aabbccddeeff;
  localparam logic [127:0] CT  = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
  localparam logic [127:0] KEY = 128'h000102030405060708090a0b0c0d0e0f;

  logic         clk, rst;
  logic         enc_valid, enc_ready, dec_valid, dec_ready;
  logic [127:0] enc_data, dec_data;
  logic         round_start, round_mode, round_last, round_done;
  logic [3:0]   round_num, round_key_idx;
  logic [127:0] round_state_in, round_state_out;
  logic         out_valid, out_ready, out_is_dec, busy;
  logic [127:0] out_data;

  aes_core_scheduler #(.NUM_ROUNDS(10)) dut (
    .clk(clk), .rst(rst),
    .enc_valid(enc_valid), .enc_ready(enc_ready), .enc_data(enc_data),
    .dec_valid(dec_valid), .dec_ready(dec_ready), .dec_data(dec_data),
    .round_start(round_start), .round_num(round_num), .round_key_idx(round_key_idx),
    .round_mode(round_mode), .round_last(round_last), .round_state_in(round_state_in),
    .round_done(round_done), .round_state_out(round_state_out),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
    .out_is_dec(out_is_dec), .busy(busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_chk = 0, n_pass = 0;

  task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h want %h (cycle %0d)", nm, act, exp, cyc);
  endtask

  task automatic timeout(input string nm);
    n_chk++;
    $display("FAIL %s: timed out at cycle %0d", nm, cyc);
  endtask

  // ---------------- AES reference round core ----------------
  logic [7:0]   sbox [256];
  logic [7:0]   isbox[256];
  logic [127:0] rk   [0:10];

  function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p, x, y;
    p = 8'h00; x = a; y = b;
    for (int i = 0; i < 8; i++) begin
      if (y[0]) p = p ^ x;
      x = x[7] ? ({x[6:0], 1'b0} ^ 8'h1b) : {x[6:0], 1'b0};
      y = {1'b0, y[7:1]};
    end
    return p;
  endfunction

  function automatic logic [7:0] rotl1(input logic [7:0] b);
    return {b[6:0], b[7]};
  endfunction

  function automatic logic [127:0] sub_shift(input logic [127:0] s, input bit inv);
    logic [127:0] o;
    int r, c, src;
    o = '0;
    for (int i = 0; i < 16; i++) begin
      r = i % 4; c = i / 4;
      src = inv ? (r + 4 * ((c - r + 4) % 4)) : (r + 4 * ((c + r) % 4));
      o[127-8*i -: 8] = inv ? isbox[s[127-8*src -: 8]] : sbox[s[127-8*src -: 8]];
    end
    return o;
  endfunction

  function automatic logic [127:0] mix(input logic [127:0] s, input bit inv);
    logic [7:0] a [4];
    logic [7:0] cf[4];
    logic [7:0] acc;
    logic [127:0] o;
    if (inv) begin cf[0] = 8'h0e; cf[1] = 8'h0b; cf[2] = 8'h0d; cf[3] = 8'h09; end
    else     begin cf[0] = 8'h02; cf[1] = 8'h03; cf[2] = 8'h01; cf[3] = 8'h01; end
    o = '0;
    for (int c = 0; c < 4; c++) begin
      for (int j = 0; j < 4; j++) a[j] = s[127-8*(4*c+j) -: 8];
      for (int j = 0; j < 4; j++) begin
        acc = 8'h00;
        for (int q = 0; q < 4; q++) acc = acc ^ gmul(a[q], cf[(q - j + 4) % 4]);
        o[127-8*(4*c+j) -: 8] = acc;
      end
    end
    return o;
  endfunction

  function automatic logic [127:0] aes_round(input logic [127:0] s, input int k, input logic dec);
    logic [127:0] t;
    if (k == 0) t = s ^ (dec ? rk[10] : rk[0]);
    else if (!dec) begin
      t = sub_shift(s, 1'b0);
      if (k != 10) t = mix(t, 1'b0);
      t = t ^ rk[k];
    end else begin
      t = sub_shift(s, 1'b1) ^ rk[10-k];
      if (k != 10) t = mix(t, 1'b1);
    end
    return t;
  endfunction

  task automatic build_tables();
    logic [7:0] inv, s;
    logic [31:0] w[0:43];
    logic [31:0] tmp;
    logic [7:0] rc;
    logic [127:0] key_v;
    for (int x = 0; x < 256; x++) begin
      inv = 8'h01;
      if (x == 0) inv = 8'h00;
      else for (int e = 0; e < 254; e++) inv = gmul(inv, 8'(x));
      s = inv ^ rotl1(inv) ^ rotl1(rotl1(inv)) ^ rotl1(rotl1(rotl1(inv)))
          ^ rotl1(rotl1(rotl1(rotl1(inv)))) ^ 8'h63;
      sbox[x]  = s;
      isbox[s] = 8'(x);
    end
    key_v = KEY;
    for (int i = 0; i < 4; i++) w[i] = key_v[127-32*i -: 32];
    rc = 8'h01;
    for (int i = 4; i < 44; i++) begin
      tmp = w[i-1];
      if (i % 4 == 0) begin
        tmp = {tmp[23:0], tmp[31:24]};
        tmp = {sbox[tmp[31:24]] ^ rc, sbox[tmp[23:16]], sbox[tmp[15:8]], sbox[tmp[7:0]]};
        rc = rc[7] ? ({rc[6:0], 1'b0} ^ 8'h1b) : {rc[6:0], 1'b0};
      end
      w[i] = w[i-4] ^ tmp;
    end
    for (int r = 0; r <= 10; r++) rk[r] = {w[4*r], w[4*r+1], w[4*r+2], w[4*r+3]};
  endtask

  // ---------------- shared bench state ----------------
  typedef struct packed { logic is_dec; logic [127:0] data; } exp_t;
  exp_t sb[$];
  logic gq[$];
  int   acc_count = 0, out_count = 0, ready_cnt = 0, acc_cyc = 0;
  logic cur_dec = 1'b0;
  int   exp_lat = 22;
  bit   tput_on = 1'b0;
  int   tie_base = 0;
  int   stall_round = 99, stall_cyc = 0, spur_round = 99;

  // Core model: answers one cycle after round_start unless told to stall
  initial begin : core
    logic [127:0] res;
    int k, seen;
    k = 0; seen = 0;
    forever begin
      @(posedge clk); #1;
      round_done = 1'b0;
      if (round_start) begin
        if (acc_count != seen) begin k = 0; seen = acc_count; end
        chk("round_num", round_num, k);
        chk("round_key_idx", round_key_idx, cur_dec ? (10 - k) : k);
        chk("round_mode", round_mode, cur_dec);
        chk("round_last", round_last, k == 10);
        res = aes_round(round_state_in, k, cur_dec);
        if (k == spur_round) begin
          round_done      = 1'b1;
          round_state_out = 128'hdeadbeef_0badf00d_cafebabe_55aa55aa;
        end
        @(posedge clk); #1;
        round_done = 1'b0;
        chk("round_start_gap", round_start, 1'b0);
        if (k == stall_round)
          for (int i = 0; i < stall_cyc; i++) begin @(posedge clk); #1; end
        round_done      = 1'b1;
        round_state_out = res;
        k++;
      end
    end
  end

  // Monitor: records acceptances into the scoreboard, checks outputs on handshake
  initial begin : mon
    logic side, prev_ov, prev_hs, prev_isdec, hs;
    logic [127:0] prev_data;
    exp_t e;
    prev_ov = 0; prev_hs = 0; prev_isdec = 0; prev_data = '0;
    forever begin
      @(negedge clk);
      if (rst) begin
        sb.delete();
        prev_ov = 0; prev_hs = 0;
      end else begin
        if (prev_hs) chk("idle_after_hs", {busy, out_valid}, 2'b00);
        if (enc_ready || dec_ready) begin
          ready_cnt++;
          chk("ready_onehot", enc_ready & dec_ready, 1'b0);
          chk("ready_needs_valid", (enc_ready & ~enc_valid) | (dec_ready & ~dec_valid), 1'b0);
          side = dec_ready;
          if (gq.size() == 0) begin
            n_chk++;
            $display("FAIL grant: unexpected acceptance side=%0d", side);
          end else chk("grant", side, gq.pop_front());
          if (tput_on && acc_count > tie_base) chk("throughput", cyc + 1 - acc_cyc, 24);
          sb.push_back({side, side ? PT : CT});
          acc_cyc = cyc + 1;
          cur_dec = side;
          acc_count++;
        end
        hs = out_valid && out_ready;
        if (out_valid) begin
          if (!prev_ov) chk("latency", cyc - acc_cyc, exp_lat);
          else if (!prev_hs) begin
            chk("hold_data", out_data, prev_data);
            chk("hold_is_dec", out_is_dec, prev_isdec);
          end
          if (!out_ready) chk("quiet_in_result", {enc_ready, dec_ready, round_start}, 3'b000);
          if (out_ready) begin
            if (sb.size() == 0) begin
              n_chk++;
              $display("FAIL out_extra: unexpected result %h", out_data);
            end else begin
              e = sb.pop_front();
              chk("out_data", out_data, e.data);
              chk("out_is_dec", out_is_dec, e.is_dec);
            end
            out_count++;
          end
        end
        prev_ov = out_valid; prev_hs = hs; prev_data = out_data; prev_isdec = out_is_dec;
      end
    end
  end

  // ---------------- stimulus ----------------
  task automatic wait_acc(input int tgt);
    for (int t = 0; t < 300 && acc_count < tgt; t++) begin @(posedge clk); #1; end
    if (acc_count < tgt) timeout("accept");
  endtask

  task automatic wait_out(input int tgt);
    for (int t = 0; t < 300 && out_count < tgt; t++) begin @(posedge clk); #1; end
    if (out_count < tgt) timeout("result");
  endtask

  task automatic issue(input logic is_dec);
    gq.push_back(is_dec);
    @(posedge clk); #1;
    enc_valid = !is_dec; dec_valid = is_dec;
    wait_acc(acc_count + 1);
    enc_valid = 1'b0; dec_valid = 1'b0;
  endtask

  task automatic check_zero_outputs(input string nm);
    chk({nm, "_ctl"}, {enc_ready, dec_ready, round_start, round_num, round_key_idx,
                       round_mode, round_last, out_valid, out_is_dec, busy}, 16'h0);
    chk({nm, "_state_in"}, round_state_in, 128'h0);
    chk({nm, "_out_data"}, out_data, 128'h0);
  endtask

  initial begin : stim
    int base;
    enc_valid = 0; dec_valid = 0; enc_data = PT; dec_data = CT;
    round_done = 0; round_state_out = '0; out_ready = 1;
    rst = 1'b0;
    build_tables();
    #2 rst = 1'b1;
    #3 check_zero_outputs("reset");
    repeat (2) @(negedge clk);
    rst = 1'b0;

    // single encrypt, then single decrypt
    issue(1'b0); wait_out(1);
    issue(1'b1); wait_out(2);

    // four-block tie: grants alternate enc, dec, enc, dec at one block per 24 cycles
    base = ready_cnt; tie_base = acc_count; tput_on = 1'b1;
    gq.push_back(1'b0); gq.push_back(1'b1); gq.push_back(1'b0); gq.push_back(1'b1);
    @(posedge clk); #1;
    enc_valid = 1'b1; dec_valid = 1'b1;
    wait_acc(acc_count + 4);
    enc_valid = 1'b0; dec_valid = 1'b0;
    wait_out(6);
    tput_on = 1'b0;
    chk("ready_pulses", ready_cnt - base, 4);

    // consumer stalls 10 cycles while a decrypt request waits behind the result
    out_ready = 1'b0;
    issue(1'b0);
    for (int t = 0; t < 100 && !out_valid; t++) begin @(posedge clk); #1; end
    if (!out_valid) timeout("stall_result");
    gq.push_back(1'b1);
    dec_valid = 1'b1;
    repeat (10) @(posedge clk);
    #1 out_ready = 1'b1;
    wait_acc(acc_count + 1);
    dec_valid = 1'b0;
    wait_out(8);

    // core stalls 5 cycles in round 3 with a spurious done during its ISSUE
    stall_round = 3; stall_cyc = 5; spur_round = 3; exp_lat = 27;
    issue(1'b0); wait_out(9);
    stall_round = 99; spur_round = 99; exp_lat = 22;

    // reset while waiting on round 6; block is dropped and arbitration restarts
    issue(1'b0);
    begin : find_r6
      bit hit;
      hit = 0;
      for (int t = 0; t < 100; t++) begin
        @(negedge clk);
        if (busy && !round_start && !out_valid && round_num == 4'd6) begin hit = 1; break; end
      end
      if (!hit) timeout("round6");
    end
    #2 rst = 1'b1;
    #1 check_zero_outputs("async_rst");
    repeat (2) @(negedge clk);
    #2 rst = 1'b0;
    @(negedge clk);
    chk("busy_after_rst", busy, 1'b0);
    gq.push_back(1'b0);
    @(posedge clk); #1;
    enc_valid = 1'b1; dec_valid = 1'b1;
    wait_acc(acc_count + 1);
    enc_valid = 1'b0; dec_valid = 1'b0;
    wait_out(10);

    repeat (3) @(posedge clk);
    chk("scoreboard_empty", sb.size(), 0);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

  initial begin : watchdog
    #200000;
    $display("FAIL watchdog: simulation did not finish by cycle %0d", cyc);
    $fatal(1, "watchdog");
  end

endmodule
